// File: rtl/clkmon_pkg.sv
// Shared types, width helper and default limits for the clock frequency monitor.
package clkmon_pkg;

    typedef enum logic {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } lock_state_e;

    // Bits needed to hold values 0..value-1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned width;
        width = 0;
        for (longint unsigned v = 1; v < longint'(value); v = v << 1) begin
            width++;
        end
        return width;
    endfunction

    // Transitions per 1024-cycle window at a 400 MHz reference, roughly +/-2%.
    localparam int unsigned DefMin74m25  = 186;
    localparam int unsigned DefMax74m25  = 194;
    localparam int unsigned DefMin125m   = 313;
    localparam int unsigned DefMax125m   = 327;
    localparam int unsigned DefMin156m25 = 392;
    localparam int unsigned DefMax156m25 = 408;

endpackage

// File: rtl/clkmon_channel.sv
// One monitored channel: toggle synchroniser, saturating edge counter,
// range compare and lock FSM with a lock-loss pulse on the terminal cycle.
module clkmon_channel
    import clkmon_pkg::*;
#(
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned LOCK_CNT = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             toggle_i,
    input  logic             terminal_i,
    input  logic [CNT_W-1:0] min_cnt_i,
    input  logic [CNT_W-1:0] max_cnt_i,
    output logic             locked_o,
    output logic [CNT_W-1:0] cnt_o,
    output logic             lock_loss_o
);

    localparam int unsigned RunW = clog2(LOCK_CNT + 1);
    localparam logic [RunW-1:0] RunLast = RunW'(LOCK_CNT - 1);

    logic             sync1_q, sync2_q, hist_q;
    logic             trans;
    logic [CNT_W-1:0] edge_q, edge_d, closing, cnt_q;
    logic             in_range;
    lock_state_e      state_q, state_d;
    logic [RunW-1:0]  run_q, run_d;

    assign trans    = sync2_q ^ hist_q;
    // Saturate rather than wrap so a runaway clock never reads as in range.
    assign closing  = (trans && (edge_q != '1)) ? edge_q + 1'b1 : edge_q;
    assign edge_d   = terminal_i ? '0 : closing;
    assign in_range = (closing >= min_cnt_i) && (closing <= max_cnt_i);

    always_comb begin
        state_d     = state_q;
        run_d       = run_q;
        lock_loss_o = 1'b0;
        if (terminal_i) begin
            case (state_q)
                ST_UNLOCKED: begin
                    if (!in_range) begin
                        run_d = '0;
                    end else if (run_q == RunLast) begin
                        state_d = ST_LOCKED;
                        run_d   = '0;
                    end else begin
                        run_d = run_q + 1'b1;
                    end
                end
                ST_LOCKED: begin
                    if (!in_range) begin
                        state_d     = ST_UNLOCKED;
                        run_d       = '0;
                        lock_loss_o = 1'b1;
                    end
                end
                default: state_d = ST_UNLOCKED;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            hist_q  <= 1'b0;
            edge_q  <= '0;
            cnt_q   <= '0;
            state_q <= ST_UNLOCKED;
            run_q   <= '0;
        end else begin
            sync1_q <= toggle_i;
            sync2_q <= sync1_q;
            hist_q  <= sync2_q;
            edge_q  <= edge_d;
            if (terminal_i) begin
                cnt_q <= closing;
            end
            state_q <= state_d;
            run_q   <= run_d;
        end
    end

    assign locked_o = (state_q == ST_LOCKED);
    assign cnt_o    = cnt_q;

endmodule

// File: rtl/clock_freq_monitor.sv
// Multi-channel clock frequency/health monitor with a shared measurement window.
// Define CLKMON_IRQ_EN to build the sticky lock-loss interrupt flop.
module clock_freq_monitor
    import clkmon_pkg::*;
#(
    parameter int unsigned N_CH     = 3,
    parameter int unsigned WINDOW   = 1024,
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned LOCK_CNT = 4
) (
    input  logic                  i_CLK,
    input  logic                  i_RST,
    input  logic [N_CH-1:0]       i_TOGGLE,
    input  logic [N_CH*CNT_W-1:0] i_MIN_CNT,
    input  logic [N_CH*CNT_W-1:0] i_MAX_CNT,
    input  logic                  i_IRQ_CLR,
    output logic [N_CH-1:0]       o_LOCKED,
    output logic                  o_ALL_LOCKED,
    output logic [N_CH*CNT_W-1:0] o_CNT,
    output logic                  o_WIN_STB,
    output logic                  o_IRQ
);

    localparam int unsigned WinW = clog2(WINDOW);
    localparam logic [WinW-1:0] WinLast = WinW'(WINDOW - 1);

    logic [WinW-1:0] win_q;
    logic            terminal;
    logic            stb_q;
    logic [N_CH-1:0] lock_loss;

    assign terminal = (win_q == WinLast);

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            win_q <= '0;
            stb_q <= 1'b0;
        end else begin
            win_q <= terminal ? '0 : win_q + 1'b1;
            stb_q <= terminal;
        end
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        clkmon_channel #(
            .CNT_W    (CNT_W),
            .LOCK_CNT (LOCK_CNT)
        ) u_channel (
            .clk_i       (i_CLK),
            .rst_i       (i_RST),
            .toggle_i    (i_TOGGLE[k]),
            .terminal_i  (terminal),
            .min_cnt_i   (i_MIN_CNT[k*CNT_W +: CNT_W]),
            .max_cnt_i   (i_MAX_CNT[k*CNT_W +: CNT_W]),
            .locked_o    (o_LOCKED[k]),
            .cnt_o       (o_CNT[k*CNT_W +: CNT_W]),
            .lock_loss_o (lock_loss[k])
        );
    end

    assign o_ALL_LOCKED = &o_LOCKED;
    assign o_WIN_STB    = stb_q;

`ifdef CLKMON_IRQ_EN
    logic irq_q;

    // A new loss outranks a coincident clear.
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            irq_q <= 1'b0;
        end else if (|lock_loss) begin
            irq_q <= 1'b1;
        end else if (i_IRQ_CLR) begin
            irq_q <= 1'b0;
        end
    end

    assign o_IRQ = irq_q;
`else
    logic unused_irq;
    assign unused_irq = i_IRQ_CLR ^ (|lock_loss);
    assign o_IRQ      = 1'b0;
`endif

endmodule

// File: tb/tb_clock_freq_monitor.sv
// Randomised scoreboard bench for clock_freq_monitor against a window-level reference model.
module tb_clock_freq_monitor;

    localparam int N_CH     = 3;
    localparam int WINDOW   = 1024;
    localparam int CNT_W    = 9;
    localparam int LOCK_CNT = 4;
    localparam int MAXC     = (1 << CNT_W) - 1;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [N_CH-1:0]       tog = '0;
    logic [N_CH*CNT_W-1:0] min_cnt = '0;
    logic [N_CH*CNT_W-1:0] max_cnt = '0;
    logic                  irq_clr = 1'b0;
    logic [N_CH-1:0]       locked;
    logic                  all_locked;
    logic [N_CH*CNT_W-1:0] cnt;
    logic                  win_stb;
    logic                  irq;

    always #5 clk = ~clk;

    clock_freq_monitor #(
        .N_CH     (N_CH),
        .WINDOW   (WINDOW),
        .CNT_W    (CNT_W),
        .LOCK_CNT (LOCK_CNT)
    ) dut (
        .i_CLK        (clk),
        .i_RST        (rst),
        .i_TOGGLE     (tog),
        .i_MIN_CNT    (min_cnt),
        .i_MAX_CNT    (max_cnt),
        .i_IRQ_CLR    (irq_clr),
        .o_LOCKED     (locked),
        .o_ALL_LOCKED (all_locked),
        .o_CNT        (cnt),
        .o_WIN_STB    (win_stb),
        .o_IRQ        (irq)
    );

    typedef struct packed {
        int                    due;
        logic [N_CH*CNT_W-1:0] cnt;
        logic [N_CH-1:0]       locked;
        logic                  irq;
    } exp_t;

    int total = 0;
    int bad   = 0;

    // Reference model state: sampled input history and per-window lock bookkeeping.
    logic [N_CH-1:0] samples[$];
    exp_t            sb[$];
    int              edges = 0;
    int              run_m[N_CH];
    logic [N_CH-1:0] lk_m = '0;
    logic            irq_m = 1'b0;

    // Stimulus controls: 0 static, 1 periodic, 2 random.
    int mode[N_CH];
    int per[N_CH];
    int ph[N_CH];
    bit extra = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, edges);
        end
    endtask

    function automatic logic [N_CH-1:0] samp(input int j);
        if (j < 0) return '0;
        return samples[j];
    endfunction

    // Window k closes at edge n; the synchroniser delays each input change by two edges,
    // so that window counts changes in samples[n-WINDOW-1 .. n-2].
    initial begin : model
        exp_t            e;
        logic [N_CH-1:0] a, b;
        int              n, c, lo, hi;
        bit              loss, term, inr;
        forever begin
            @(posedge clk);
            if (!rst) begin
                samples.push_back(tog);
                n     = edges;
                edges = edges + 1;
                loss  = 1'b0;
                term  = (n % WINDOW) == (WINDOW - 1);
                if (term) begin
                    e     = '0;
                    e.due = edges;
                    for (int ch = 0; ch < N_CH; ch++) begin
                        c = 0;
                        for (int j = n - WINDOW - 1; j <= n - 2; j++) begin
                            a = samp(j);
                            b = samp(j - 1);
                            if (a[ch] != b[ch]) c++;
                        end
                        if (c > MAXC) c = MAXC;
                        lo  = int'(min_cnt[ch*CNT_W +: CNT_W]);
                        hi  = int'(max_cnt[ch*CNT_W +: CNT_W]);
                        inr = (c >= lo) && (c <= hi);
                        if (lk_m[ch]) begin
                            if (!inr) begin
                                lk_m[ch]  = 1'b0;
                                run_m[ch] = 0;
                                loss      = 1'b1;
                            end
                        end else if (inr) begin
                            run_m[ch]++;
                            if (run_m[ch] == LOCK_CNT) begin
                                lk_m[ch]  = 1'b1;
                                run_m[ch] = 0;
                            end
                        end else begin
                            run_m[ch] = 0;
                        end
                        e.cnt[ch*CNT_W +: CNT_W] = CNT_W'(c);
                    end
                    e.locked = lk_m;
                end
`ifdef CLKMON_IRQ_EN
                if (loss) irq_m = 1'b1;
                else if (irq_clr) irq_m = 1'b0;
`endif
                if (term) begin
                    e.irq = irq_m;
                    sb.push_back(e);
                end
            end
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                check("locked", int'(locked), int'(lk_m));
                check("all_locked", int'(all_locked), int'(&lk_m));
                check("irq", int'(irq), int'(irq_m));
                if (win_stb) begin
                    if (sb.size() == 0) begin
                        check("spurious_strobe", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        check("strobe_cycle", edges, e.due);
                        for (int ch = 0; ch < N_CH; ch++) begin
                            check($sformatf("cnt%0d", ch), int'(cnt[ch*CNT_W +: CNT_W]),
                                  int'(e.cnt[ch*CNT_W +: CNT_W]));
                        end
                        check("strobe_locked", int'(locked), int'(e.locked));
                        check("strobe_irq", int'(irq), int'(e.irq));
                    end
                end else if (sb.size() > 0 && sb[0].due < edges) begin
                    e = sb.pop_front();
                    check("missing_strobe", 0, 1);
                end
            end
        end
    end

    task automatic check_zero(input string name);
        check({name, "_locked"}, int'(locked), 0);
        check({name, "_all"}, int'(all_locked), 0);
        check({name, "_cnt"}, (cnt != '0) ? 1 : 0, 0);
        check({name, "_stb"}, int'(win_stb), 0);
        check({name, "_irq"}, int'(irq), 0);
    endtask

    task automatic run(input int cycles);
        repeat (cycles) begin
            @(negedge clk);
            for (int ch = 0; ch < N_CH; ch++) begin
                if (ch == 0 && extra && (edges % WINDOW) == WINDOW - 3) begin
                    tog[0] = ~tog[0];
                    ph[0]  = 0;
                end else if (mode[ch] == 1) begin
                    ph[ch]++;
                    if (ph[ch] >= per[ch]) begin
                        ph[ch]  = 0;
                        tog[ch] = ~tog[ch];
                    end
                end else if (mode[ch] == 2) begin
                    if ($urandom_range(7) == 0) tog[ch] = ~tog[ch];
                end
            end
        end
    endtask

    task automatic set_limits(input int ch, input int lo, input int hi);
        min_cnt[ch*CNT_W +: CNT_W] = CNT_W'(lo);
        max_cnt[ch*CNT_W +: CNT_W] = CNT_W'(hi);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_zero("async_reset");
        samples.delete();
        sb.delete();
        edges = 0;
        lk_m  = '0;
        irq_m = 1'b0;
        for (int ch = 0; ch < N_CH; ch++) run_m[ch] = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin : stimulus
        for (int ch = 0; ch < N_CH; ch++) begin
            run_m[ch] = 0;
            ph[ch]    = 0;
        end
        set_limits(0, 250, 262);
        set_limits(1, 1, 600);
        set_limits(2, 100, 160);
        mode[0] = 1; per[0] = 4;
        mode[1] = 0; per[1] = 2;
        mode[2] = 2; per[2] = 8;

        repeat (3) @(negedge clk);
        check_zero("reset_state");
        rst = 1'b0;

        // ch0 locks on the 4th window; ch1 static stays unlocked.
        run(6 * WINDOW);
        // Extra ch0 transition landing on the terminal cycle.
        extra = 1'b1;
        run(2 * WINDOW);
        extra = 1'b0;
        // Stop ch0 mid-window: lock loss at the next boundary, then clear the flag.
        run(WINDOW / 2);
        mode[0] = 0;
        run(2 * WINDOW);
        @(negedge clk);
        irq_clr = 1'b1;
        @(negedge clk);
        irq_clr = 1'b0;
        @(negedge clk);
        check("irq_cleared", int'(irq), 0);
        // ch1 toggling every 2 cycles saturates the counter.
        mode[1] = 1;
        run(3 * WINDOW);
        // Relock ch0, then reset mid-window.
        mode[0] = 1;
        run(5 * WINDOW + 300);
        do_reset();
        run(5 * WINDOW);
        // MIN > MAX on ch2: never locks.
        set_limits(2, 200, 100);
        mode[2] = 1;
        run(6 * WINDOW);
        run(4);
        check("scoreboard_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
